// File: rtl/uart_rx_frame.sv
// Multi-word UART receiver: deserialises WORD_COUNT words from rx_i into one wide frame,
// reporting parity, framing and inter-word timeout errors as single-cycle pulses.
module uart_rx_frame #(
  parameter int         CLK_RATE     = 10_000_000,
  parameter int         BAUD_RATE    = 115200,
  parameter int         WORD_LEN     = 8,
  parameter int         WORD_COUNT   = 16,
  parameter logic [7:0] PARITY       = "L",
  parameter int         STOP         = 1,
  parameter int         IDLE_TIMEOUT = 20
) (
  input  logic                           ref_clk_buf,
  input  logic                           rst,
  input  logic                           rx_i,
  output logic [WORD_COUNT*WORD_LEN-1:0] rx_data_o,
  output logic                           rx_valid_o,
  output logic                           rx_busy_o,
  output logic                           parity_err_o,
  output logic                           frame_err_o,
  output logic                           timeout_o
);

  localparam int DIV      = CLK_RATE / BAUD_RATE;
  localparam int TW       = $clog2(DIV);
  localparam int IDLE_CYC = IDLE_TIMEOUT * DIV;
  localparam int IW       = $clog2(IDLE_CYC + 1);
  localparam int CW       = $clog2(WORD_COUNT + 1);
  localparam int FW       = WORD_COUNT * WORD_LEN;

  localparam logic [TW-1:0] HALF_T    = TW'(DIV / 2);
  localparam logic [TW-1:0] LAST_T    = TW'(DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] WC_LAST   = CW'(WORD_COUNT - 1);
  localparam logic [3:0]    WL_LAST   = 4'(WORD_LEN - 1);
  localparam logic [3:0]    ST_LAST   = 4'(STOP - 1);
  localparam bit            HAS_PAR   = (PARITY != "N");

  if (DIV < 4) begin : g_div_chk
    $error("uart_rx_frame: CLK_RATE/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PAR     = 3'd3,
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  rxs_prev_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [WORD_LEN-1:0]   shift_q, shift_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic [FW-1:0]         staging_q, staging_d;
  logic [FW-1:0]         data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  tmo_q, tmo_d;
  logic                  rxs_s, fall_s, tick_mid_s, tick_bit_s, exp_par_s;

  assign rxs_s      = sync_q[1];
  assign fall_s     = rxs_prev_q & ~rxs_s;
  assign tick_mid_s = (timer_q == HALF_T);
  assign tick_bit_s = (timer_q == LAST_T);

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign rx_busy_o    = busy_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign timeout_o    = tmo_q;

  always_comb begin
    case (PARITY)
      "E":     exp_par_s = ^shift_q;
      "O":     exp_par_s = ~(^shift_q);
      "H":     exp_par_s = 1'b1;
      default: exp_par_s = 1'b0;
    endcase
  end

  always_ff @(posedge ref_clk_buf or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = fall_s ? S_START : S_IDLE;
      S_START:   if (tick_mid_s) state_d = rxs_s ? S_IDLE : S_DATA;
                 else state_d = S_START;
      S_DATA:    if (tick_bit_s && (bit_cnt_q == WL_LAST)) state_d = HAS_PAR ? S_PAR : S_STOP;
                 else state_d = S_DATA;
      S_PAR:     if (tick_bit_s) state_d = (rxs_s != exp_par_s) ? S_RECOVER : S_STOP;
                 else state_d = S_PAR;
      // a stop bit is left at its mid point so the next start edge is never missed
      S_STOP:    if (tick_bit_s && !rxs_s) state_d = S_RECOVER;
                 else if (tick_bit_s && (bit_cnt_q == ST_LAST)) state_d = S_IDLE;
                 else state_d = S_STOP;
      S_RECOVER: state_d = (rxs_s && tick_bit_s) ? S_IDLE : S_RECOVER;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    idle_d     = idle_q;
    staging_d  = staging_q;
    data_d     = data_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    tmo_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (fall_s) begin
          idle_d = idle_q;
        end else if (word_cnt_q == '0) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          tmo_d      = 1'b1;
          word_cnt_d = '0;
          busy_d     = 1'b0;
          idle_d     = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      S_START: begin
        if (tick_mid_s) begin
          timer_d = '0;
          if (!rxs_s) begin
            busy_d = 1'b1;
            idle_d = '0;
          end else begin
            busy_d = busy_q;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (tick_bit_s) begin
          timer_d   = '0;
          shift_d   = {rxs_s, shift_q[WORD_LEN-1:1]};
          bit_cnt_d = (bit_cnt_q == WL_LAST) ? 4'd0 : bit_cnt_q + 4'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_PAR: begin
        if (tick_bit_s) begin
          timer_d = '0;
          if (rxs_s != exp_par_s) begin
            perr_d     = 1'b1;
            word_cnt_d = '0;
            busy_d     = 1'b0;
          end else begin
            busy_d = busy_q;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STOP: begin
        if (tick_bit_s) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!rxs_s) begin
            ferr_d     = 1'b1;
            word_cnt_d = '0;
            busy_d     = 1'b0;
          end else if (bit_cnt_q == ST_LAST) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
              if (word_cnt_q == CW'(i)) staging_d[i*WORD_LEN +: WORD_LEN] = shift_q;
              else staging_d[i*WORD_LEN +: WORD_LEN] = staging_q[i*WORD_LEN +: WORD_LEN];
            end
            if (word_cnt_q == WC_LAST) begin
              data_d     = staging_d;
              valid_d    = 1'b1;
              word_cnt_d = '0;
              busy_d     = 1'b0;
            end else begin
              word_cnt_d = word_cnt_q + CW'(1);
            end
          end else begin
            busy_d = busy_q;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      // the line must stay high for a whole bit before a new start edge is trusted
      S_RECOVER: begin
        bit_cnt_d = '0;
        if (!rxs_s || tick_bit_s) timer_d = '0;
        else timer_d = timer_q + TW'(1);
      end
      default: begin
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge ref_clk_buf or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      idle_q     <= '0;
      staging_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_i};
      rxs_prev_q <= rxs_s;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      idle_q     <= idle_d;
      staging_q  <= staging_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a 4-word receiver (DIV=10) driven from a vector table plus corner
// sequences, and a 16-word receiver (DIV=86) fed by a modelled transmitter at nominal and +/-2% rate.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  logic clk = 1'b0;
  logic rst, rx_a, rx_b;
  logic [31:0]  data_a;
  logic [127:0] data_b;
  logic valid_a, busy_a, perr_a, ferr_a, tmo_a;
  logic valid_b, busy_b, perr_b, ferr_b, tmo_b;

  int n_checks = 0, n_fail = 0;
  int nv_a = 0, np_a = 0, nf_a = 0, nt_a = 0, nb_a = 0, nv_b = 0, ne_b = 0;
  int s_v, s_p, s_f, s_t, s_b, cnt;

  localparam logic [127:0] FRAME_B = 128'h0123456789ABCDEF_FEDCBA9876543210;

  typedef struct {
    logic [31:0] words;
    logic [3:0]  par;
    int          nwords;
    int          ev, ep, ef, et;
    logic [31:0] edata;
  } vec_t;
  vec_t vecs [7];

  uart_rx_frame #(.CLK_RATE(1_152_000), .BAUD_RATE(115200), .WORD_LEN(8), .WORD_COUNT(4),
                  .PARITY("L"), .STOP(1), .IDLE_TIMEOUT(20)) u_dut_a (
    .ref_clk_buf(clk), .rst(rst), .rx_i(rx_a), .rx_data_o(data_a), .rx_valid_o(valid_a),
    .rx_busy_o(busy_a), .parity_err_o(perr_a), .frame_err_o(ferr_a), .timeout_o(tmo_a));

  uart_rx_frame #(.CLK_RATE(10_000_000), .BAUD_RATE(115200), .WORD_LEN(8), .WORD_COUNT(16),
                  .PARITY("L"), .STOP(1), .IDLE_TIMEOUT(20)) u_dut_b (
    .ref_clk_buf(clk), .rst(rst), .rx_i(rx_b), .rx_data_o(data_b), .rx_valid_o(valid_b),
    .rx_busy_o(busy_b), .parity_err_o(perr_b), .frame_err_o(ferr_b), .timeout_o(tmo_b));

  always #5 clk = ~clk;

  // pulse and busy-cycle counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (valid_a) nv_a <= nv_a + 1;
    if (perr_a)  np_a <= np_a + 1;
    if (ferr_a)  nf_a <= nf_a + 1;
    if (tmo_a)   nt_a <= nt_a + 1;
    if (busy_a)  nb_a <= nb_a + 1;
    if (valid_b) nv_b <= nv_b + 1;
    if (perr_b || ferr_b || tmo_b) ne_b <= ne_b + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // per_x100: bit period in hundredths of a clock cycle, so fractional rates can be modelled
  task automatic send_word(input int sel, input logic [7:0] d, input logic par, input logic stp,
                           input int per_x100);
    logic [10:0] bits;
    int t, tgt;
    bits = {stp, par, d, 1'b0};
    t = 0;
    for (int k = 0; k < 11; k++) begin
      if (sel == 0) rx_a = bits[k];
      else rx_b = bits[k];
      tgt = ((k + 1) * per_x100) / 100;
      while (t < tgt) begin
        @(negedge clk);
        t++;
      end
    end
  endtask

  task automatic send_frame_a(input logic [31:0] w, input logic [3:0] par, input int n);
    for (int i = 0; i < n; i++) send_word(0, w[8*i +: 8], par[i], 1'b1, 1000);
  endtask

  task automatic send_frame_b(input logic [127:0] f, input int per_x100);
    for (int i = 0; i < 16; i++) send_word(1, f[8*i +: 8], 1'b0, 1'b1, per_x100);
  endtask

  task automatic glitch_a();
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'h44332211, 4'b0000, 4, 1, 0, 0, 0, 32'h44332211};
    vecs[1] = '{32'h44332211, 4'b0100, 3, 0, 1, 0, 0, 32'h44332211};
    vecs[2] = '{32'hA1B2C3D4, 4'b0000, 4, 1, 0, 0, 0, 32'hA1B2C3D4};
    vecs[3] = '{32'h0000BEEF, 4'b0000, 2, 0, 0, 0, 1, 32'hA1B2C3D4};
    vecs[4] = '{32'h5A0FF0A5, 4'b0000, 4, 1, 0, 0, 0, 32'h5A0FF0A5};
    vecs[5] = '{32'hFF00FF00, 4'b0001, 1, 0, 1, 0, 0, 32'h5A0FF0A5};
    vecs[6] = '{32'hFF00FF00, 4'b0000, 4, 1, 0, 0, 0, 32'hFF00FF00};

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data_a", data_a, 32'h0);
    check("reset_valid_a", valid_a, 1'b0);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_errs_a", {perr_a, ferr_a, tmo_a}, 3'b000);
    check("reset_data_b", data_b, 128'h0);
    check("reset_busy_b", busy_b, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      s_v = nv_a; s_p = np_a; s_f = nf_a; s_t = nt_a;
      send_frame_a(vecs[i].words, vecs[i].par, vecs[i].nwords);
      repeat (300) @(negedge clk);
      check($sformatf("vec%0d_valid_pulses", i), nv_a - s_v, vecs[i].ev);
      check($sformatf("vec%0d_parity_pulses", i), np_a - s_p, vecs[i].ep);
      check($sformatf("vec%0d_frame_pulses", i), nf_a - s_f, vecs[i].ef);
      check($sformatf("vec%0d_timeout_pulses", i), nt_a - s_t, vecs[i].et);
      check($sformatf("vec%0d_data", i), data_a, vecs[i].edata);
      check($sformatf("vec%0d_busy_idle", i), busy_a, 1'b0);
    end

    // inter-word timeout: 200 idle cycles after the last stop sample
    s_v = nv_a; s_t = nt_a;
    send_word(0, 8'h11, 1'b0, 1'b1, 1000);
    send_word(0, 8'h22, 1'b0, 1'b1, 1000);
    check("tmo_busy_partial", busy_a, 1'b1);
    cnt = 0;
    while (!tmo_a && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo_cycle_window", (cnt >= 196 && cnt <= 202), 1'b1);
    check("tmo_busy_dropped", busy_a, 1'b0);
    repeat (5) @(negedge clk);
    check("tmo_pulse_count", nt_a - s_t, 1);
    check("tmo_data_kept", data_a, 32'hFF00FF00);
    send_frame_a(32'h0D0C0B0A, 4'b0000, 4);
    repeat (50) @(negedge clk);
    check("tmo_next_frame_data", data_a, 32'h0D0C0B0A);
    check("tmo_next_frame_valid", nv_a - s_v, 1);

    // short glitches: on an idle line, then between words of a frame
    s_v = nv_a; s_p = np_a; s_f = nf_a; s_t = nt_a; s_b = nb_a;
    glitch_a();
    repeat (40) @(negedge clk);
    check("glitch_no_busy", nb_a - s_b, 0);
    check("glitch_no_pulses", (nv_a - s_v) + (np_a - s_p) + (nf_a - s_f) + (nt_a - s_t), 0);
    send_word(0, 8'h66, 1'b0, 1'b1, 1000);
    repeat (5) @(negedge clk);
    glitch_a();
    repeat (30) @(negedge clk);
    send_frame_a(32'h99887700, 4'b0000, 4'd0);
    send_word(0, 8'h77, 1'b0, 1'b1, 1000);
    send_word(0, 8'h88, 1'b0, 1'b1, 1000);
    send_word(0, 8'h99, 1'b0, 1'b1, 1000);
    repeat (50) @(negedge clk);
    check("glitch_mid_frame_data", data_a, 32'h99887766);
    check("glitch_mid_frame_valid", nv_a - s_v, 1);
    check("glitch_mid_frame_errs", (np_a - s_p) + (nf_a - s_f) + (nt_a - s_t), 0);

    // framing error on word 1, line then stuck low for 50 cycles
    s_v = nv_a; s_f = nf_a; s_t = nt_a;
    send_word(0, 8'h12, 1'b0, 1'b1, 1000);
    send_word(0, 8'h34, 1'b0, 1'b0, 1000);
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    check("ferr_pulse_count", nf_a - s_f, 1);
    check("ferr_no_valid", nv_a - s_v, 0);
    check("ferr_busy_dropped", busy_a, 1'b0);
    check("ferr_data_kept", data_a, 32'h99887766);
    send_frame_a(32'hCAFEF00D, 4'b0000, 4);
    repeat (300) @(negedge clk);
    check("ferr_next_frame_data", data_a, 32'hCAFEF00D);
    check("ferr_next_frame_valid", nv_a - s_v, 1);
    check("ferr_no_timeout", nt_a - s_t, 0);

    // 16-word receiver at nominal, +2% slow and -2% fast transmit rate
    s_v = nv_b;
    send_frame_b(FRAME_B, 8600);
    repeat (200) @(negedge clk);
    check("loop_nominal_data", data_b, FRAME_B);
    send_frame_b(~FRAME_B, 8772);
    repeat (200) @(negedge clk);
    check("loop_slow_data", data_b, ~FRAME_B);
    send_frame_b(FRAME_B, 8428);
    repeat (200) @(negedge clk);
    check("loop_fast_data", data_b, FRAME_B);
    check("loop_valid_count", nv_b - s_v, 3);
    check("loop_no_errors", ne_b, 0);

    // reset in the middle of word 5
    for (int i = 0; i < 5; i++) send_word(1, FRAME_B[8*i +: 8], 1'b0, 1'b1, 8600);
    rx_b = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_busy_before", busy_b, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_data_b", data_b, 128'h0);
    check("rst_valid_b", valid_b, 1'b0);
    check("rst_data_a", data_a, 32'h0);
    rx_b = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    s_v = nv_b;
    send_frame_b(~FRAME_B, 8600);
    repeat (200) @(negedge clk);
    check("rst_next_frame_data", data_b, ~FRAME_B);
    check("rst_next_frame_valid", nv_b - s_v, 1);
    check("rst_next_busy", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
